display_timing_gen: RTL

- Generates raster timing for the game display and supplies the pixel-coordinate stream that gfx_inst consumes (i_x, i_y, i_v_sync, SPRITE_REFRESHER).
- Captures gfx_inst's RGB answer for each coordinate and drives the physical video pins (HS, VS, DE, RGB), with sync and RGB kept pixel-aligned.
- Sits between the clocking/top level and gfx_inst, at the opposite end of the coordinate→colour interface.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/display_timing_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 720p timing defaults, coordinate and pixel types
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    typedef logic [15:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Raw active-high timing flags that travel down the alignment pipeline together
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - WIDTH x DEPTH shift register with synchronous clear
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH < 1) begin : g_depth_check
        $error("sync_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/display_timing_gen.sv
// rtl/display_timing_gen.sv - raster counters, coordinate stream to the compositor and pixel-aligned video pins
module display_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int GFX_LATENCY = 0,
    parameter int REFRESH_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_v_sync,
    output logic        o_frame_tick,
    output logic        o_sprite_refresh,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_de,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam coord_t DIV_LAST = coord_t'(REFRESH_DIV - 1);
    localparam logic   HS_HIGH  = (HS_POL != 0);
    localparam logic   VS_HIGH  = (VS_POL != 0);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    coord_t frame_cnt_q, frame_cnt_d;
    rgb_t   rgb_q;
    sync_t  sync_raw;
    sync_t  sync_dly;
    logic   frame_tick;

    assign sync_raw.hs = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign sync_raw.vs = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign sync_raw.de = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // Vertical blank begins on the first pixel clock of the first non-visible line
    assign frame_tick = (h_cnt_q == '0) && (v_cnt_q == V_ACT);

    always_comb begin
        h_cnt_d     = h_cnt_q + 16'd1;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
        end
        if (frame_tick) begin
            frame_cnt_d = (frame_cnt_q == DIV_LAST) ? '0 : frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            rgb_q       <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= '{r: i_red, g: i_green, b: i_blue};
        end
    end

    // One stage beyond the compositor latency so flags meet the registered colour
    sync_delay_line #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (GFX_LATENCY + 1)
    ) u_sync_dly (
        .clk_i (i_clk),
        .clr_i (i_rst),
        .d_i   (sync_raw),
        .q_o   (sync_dly)
    );

    assign o_x              = h_cnt_q;
    assign o_y              = v_cnt_q;
    assign o_v_sync         = sync_raw.vs;
    assign o_frame_tick     = frame_tick;
    assign o_sprite_refresh = frame_tick && (frame_cnt_q == DIV_LAST);

    assign o_vga_hs = HS_HIGH ? sync_dly.hs : ~sync_dly.hs;
    assign o_vga_vs = VS_HIGH ? sync_dly.vs : ~sync_dly.vs;
    assign o_vga_de = sync_dly.de;
    assign o_vga_r  = sync_dly.de ? rgb_q.r : 8'd0;
    assign o_vga_g  = sync_dly.de ? rgb_q.g : 8'd0;
    assign o_vga_b  = sync_dly.de ? rgb_q.b : 8'd0;

endmodule
